// File: rtl/ldpc_trial_sequencer_if.sv
// Encoder/decoder side of the LDPC trial sequencer: codeword capture,
// decoder handshake and the injected error mask.
interface ldpc_trial_sequencer_if #(
  parameter int NN = 208
);
  logic          enc_valid_i;
  logic [NN-1:0] enc_cword_i;
  logic          dec_done_i;
  logic          dec_pass_i;
  logic [NN-1:0] dec_word_i;
  logic [NN-1:0] err_mask_o;
  logic          dec_start_o;

  // Sequencer side
  modport master (
    input  enc_valid_i,
    input  enc_cword_i,
    input  dec_done_i,
    input  dec_pass_i,
    input  dec_word_i,
    output err_mask_o,
    output dec_start_o
  );

  // Encoder/decoder side
  modport slave (
    output enc_valid_i,
    output enc_cword_i,
    output dec_done_i,
    output dec_pass_i,
    output dec_word_i,
    input  err_mask_o,
    input  dec_start_o
  );
endinterface

// File: rtl/ldpc_trial_sequencer.sv
// Monte-Carlo trial controller for the LDPC encode/decode path.
// Per trial: capture the encoder codeword, draw an LFSR error mask, start
// the decoder, wait for done or timeout, and score the result.
module ldpc_trial_sequencer #(
  parameter int          NN            = 208,
  parameter int          CNT_W         = 16,
  parameter logic [15:0] LFSR_SEED_DEF = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cfg_go,
  input  logic                   cfg_abort,
  input  logic [CNT_W-1:0]       cfg_num_trials,
  input  logic [7:0]             cfg_num_errs,
  input  logic [15:0]            cfg_seed,
  input  logic [15:0]            cfg_timeout,
  ldpc_trial_sequencer_if.master io,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   irq_o,
  output logic [CNT_W-1:0]       trial_cnt_o,
  output logic [CNT_W-1:0]       pass_cnt_o,
  output logic [CNT_W-1:0]       fail_cnt_o,
  output logic [CNT_W-1:0]       timeout_cnt_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENC_WAIT = 3'd1,
    ST_INJECT   = 3'd2,
    ST_START    = 3'd3,
    ST_DEC_WAIT = 3'd4,
    ST_SCORE    = 3'd5,
    ST_FINISH   = 3'd6
  } state_t;

  // Candidate positions are 8 bits wide, so compare in 9 bits.
  localparam logic [8:0] NN_LIM = 9'(NN);

  // 16-bit Fibonacci LFSR, taps 15/13/12/10, shifting left.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Saturating increment: statistics stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] r;
    if (&c) begin
      r = c;
    end else begin
      r = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  state_t           state_r, state_s;
  logic [15:0]      lfsr_r, lfsr_s;
  logic [NN-1:0]    ref_r, ref_s;
  logic [NN-1:0]    mask_r, mask_s;
  logic [7:0]       err_cnt_r, err_cnt_s;
  logic [15:0]      tmo_r, tmo_s;
  logic [CNT_W-1:0] trial_r, trial_s;
  logic [CNT_W-1:0] pass_r, pass_s;
  logic [CNT_W-1:0] fail_r, fail_s;
  logic [CNT_W-1:0] tout_r, tout_s;
  logic             done_r, done_s;
  logic             irq_r, irq_s;
  logic             busy_r;
  logic             start_r;

  logic [7:0]       pos_s;
  logic             pos_ok_s;
  logic             err_last_s;
  logic [CNT_W-1:0] trial_inc_s;
  logic             last_trial_s;
  logic             tmo_hit_s;

  assign pos_s        = lfsr_r[7:0];
  assign pos_ok_s     = ({1'b0, pos_s} < NN_LIM);
  assign err_last_s   = (({1'b0, err_cnt_r} + 9'd1) == {1'b0, cfg_num_errs});
  assign trial_inc_s  = sat_inc(trial_r);
  assign last_trial_s = (trial_inc_s == cfg_num_trials);
  assign tmo_hit_s    = (({1'b0, tmo_r} + 17'd1) >= {1'b0, cfg_timeout});

  // Next-state and datapath update; abort overrides everything and holds data.
  always_comb begin
    state_s   = state_r;
    lfsr_s    = lfsr_r;
    ref_s     = ref_r;
    mask_s    = mask_r;
    err_cnt_s = err_cnt_r;
    tmo_s     = tmo_r;
    trial_s   = trial_r;
    pass_s    = pass_r;
    fail_s    = fail_r;
    tout_s    = tout_r;
    done_s    = done_r;
    irq_s     = 1'b0;
    if (cfg_abort) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_go) begin
            trial_s = {CNT_W{1'b0}};
            pass_s  = {CNT_W{1'b0}};
            fail_s  = {CNT_W{1'b0}};
            tout_s  = {CNT_W{1'b0}};
            done_s  = 1'b0;
            mask_s  = {NN{1'b0}};
            if (cfg_seed == 16'h0000) begin
              lfsr_s = LFSR_SEED_DEF;
            end else begin
              lfsr_s = cfg_seed;
            end
            if (cfg_num_trials == {CNT_W{1'b0}}) begin
              state_s = ST_FINISH;
            end else begin
              state_s = ST_ENC_WAIT;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ENC_WAIT: begin
          if (io.enc_valid_i) begin
            ref_s     = io.enc_cword_i;
            mask_s    = {NN{1'b0}};
            err_cnt_s = 8'd0;
            state_s   = ST_INJECT;
          end else begin
            state_s = ST_ENC_WAIT;
          end
        end
        ST_INJECT: begin
          if (cfg_num_errs == 8'd0) begin
            state_s = ST_START;
          end else begin
            lfsr_s = lfsr_step(lfsr_r);
            if (pos_ok_s) begin
              mask_s[pos_s] = 1'b1;
              err_cnt_s     = err_cnt_r + 8'd1;
              if (err_last_s) begin
                state_s = ST_START;
              end else begin
                state_s = ST_INJECT;
              end
            end else begin
              state_s = ST_INJECT;
            end
          end
        end
        ST_START: begin
          tmo_s   = 16'd0;
          state_s = ST_DEC_WAIT;
        end
        ST_DEC_WAIT: begin
          if (io.dec_done_i) begin
            state_s = ST_SCORE;
          end else if (tmo_hit_s) begin
            tmo_s   = tmo_r + 16'd1;
            trial_s = trial_inc_s;
            fail_s  = sat_inc(fail_r);
            tout_s  = sat_inc(tout_r);
            if (last_trial_s) begin
              state_s = ST_FINISH;
            end else begin
              state_s = ST_ENC_WAIT;
            end
          end else begin
            tmo_s   = tmo_r + 16'd1;
            state_s = ST_DEC_WAIT;
          end
        end
        ST_SCORE: begin
          trial_s = trial_inc_s;
          if (io.dec_pass_i && (io.dec_word_i == ref_r)) begin
            pass_s = sat_inc(pass_r);
          end else begin
            fail_s = sat_inc(fail_r);
          end
          if (last_trial_s) begin
            state_s = ST_FINISH;
          end else begin
            state_s = ST_ENC_WAIT;
          end
        end
        ST_FINISH: begin
          done_s  = 1'b1;
          irq_s   = 1'b1;
          state_s = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      lfsr_r    <= LFSR_SEED_DEF;
      ref_r     <= {NN{1'b0}};
      mask_r    <= {NN{1'b0}};
      err_cnt_r <= 8'd0;
      tmo_r     <= 16'd0;
      trial_r   <= {CNT_W{1'b0}};
      pass_r    <= {CNT_W{1'b0}};
      fail_r    <= {CNT_W{1'b0}};
      tout_r    <= {CNT_W{1'b0}};
      done_r    <= 1'b0;
      irq_r     <= 1'b0;
      busy_r    <= 1'b0;
      start_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      lfsr_r    <= lfsr_s;
      ref_r     <= ref_s;
      mask_r    <= mask_s;
      err_cnt_r <= err_cnt_s;
      tmo_r     <= tmo_s;
      trial_r   <= trial_s;
      pass_r    <= pass_s;
      fail_r    <= fail_s;
      tout_r    <= tout_s;
      done_r    <= done_s;
      irq_r     <= irq_s;
      busy_r    <= (state_s != ST_IDLE);
      start_r   <= (state_s == ST_START);
    end
  end

  assign io.err_mask_o  = mask_r;
  assign io.dec_start_o = start_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;
  assign irq_o          = irq_r;
  assign trial_cnt_o    = trial_r;
  assign pass_cnt_o     = pass_r;
  assign fail_cnt_o     = fail_r;
  assign timeout_cnt_o  = tout_r;

endmodule

// File: tb/tb_ldpc_trial_sequencer.sv
// Bench for ldpc_trial_sequencer: expected decoder starts and campaign
// completions are queued by the stimulus and consumed by a monitor.
`timescale 1ns/1ps
module tb_ldpc_trial_sequencer;
  localparam int NN    = 208;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             cfg_go, cfg_abort;
  logic [CNT_W-1:0] cfg_num_trials;
  logic [7:0]       cfg_num_errs;
  logic [15:0]      cfg_seed, cfg_timeout;
  logic             busy_o, done_o, irq_o;
  logic [CNT_W-1:0] trial_cnt_o, pass_cnt_o, fail_cnt_o, timeout_cnt_o;

  ldpc_trial_sequencer_if #(.NN(NN)) bus();

  ldpc_trial_sequencer #(.NN(NN), .CNT_W(CNT_W), .LFSR_SEED_DEF(16'hACE1)) dut (
    .clk(clk), .rstn(rstn), .cfg_go(cfg_go), .cfg_abort(cfg_abort),
    .cfg_num_trials(cfg_num_trials), .cfg_num_errs(cfg_num_errs),
    .cfg_seed(cfg_seed), .cfg_timeout(cfg_timeout), .io(bus),
    .busy_o(busy_o), .done_o(done_o), .irq_o(irq_o),
    .trial_cnt_o(trial_cnt_o), .pass_cnt_o(pass_cnt_o),
    .fail_cnt_o(fail_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_irq;
    logic [NN-1:0] mask;
    logic [15:0]   t, p, f, o;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            starts_seen = 0;
  int            irqs_seen = 0;
  int            irq_exp = 0;
  bit            dec_hang = 1'b0;
  bit            dec_pass_cfg = 1'b1;
  logic [NN-1:0] dec_flip;
  int            dec_lat = 20;
  logic [NN-1:0] cword;

  task automatic check(input string name, input logic [NN-1:0] act, input logic [NN-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push_start(input logic [NN-1:0] m);
    exp_t e;
    e.is_irq = 1'b0; e.mask = m; e.t = 16'd0; e.p = 16'd0; e.f = 16'd0; e.o = 16'd0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_irq(input logic [15:0] t, input logic [15:0] p,
                                   input logic [15:0] f, input logic [15:0] o);
    exp_t e;
    e.is_irq = 1'b1; e.mask = '0; e.t = t; e.p = p; e.f = f; e.o = o;
    exp_q.push_back(e);
    irq_exp++;
  endfunction

  // Reference LFSR: feedback is the parity of the tap mask 0xB400.
  function automatic logic [NN-1:0] model_mask(input logic [15:0] seed, input int n, output int cyc);
    logic [15:0]   l;
    logic [NN-1:0] m;
    int            hits;
    m = '0; l = seed; hits = 0; cyc = 0;
    if (n == 0) begin
      cyc = 1;
    end else begin
      while (hits < n) begin
        cyc++;
        if (int'(l[7:0]) < NN) begin
          m[l[7:0]] = 1'b1;
          hits++;
        end
        l = {l[14:0], ^(l & 16'hB400)};
      end
    end
    return m;
  endfunction

  // Monitor: every decoder start and every irq consumes one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.dec_start_o === 1'b1) begin
        starts_seen++;
        if (exp_q.size() == 0 || exp_q[0].is_irq) begin
          checks++; errors++;
          $display("FAIL unexpected_start actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          check("start_mask", bus.err_mask_o, e.mask);
        end
      end
      if (irq_o === 1'b1) begin
        irqs_seen++;
        if (exp_q.size() == 0 || !exp_q[0].is_irq) begin
          checks++; errors++;
          $display("FAIL unexpected_irq actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          check("irq_done", done_o, 1);
          check("irq_trial", trial_cnt_o, e.t);
          check("irq_pass", pass_cnt_o, e.p);
          check("irq_fail", fail_cnt_o, e.f);
          check("irq_timeout", timeout_cnt_o, e.o);
        end
      end
    end
  end

  // Decoder model: answers each start after dec_lat cycles unless hung.
  initial begin
    bus.dec_done_i = 1'b0; bus.dec_pass_i = 1'b0; bus.dec_word_i = '0;
    forever begin
      @(negedge clk);
      if (bus.dec_start_o === 1'b1 && !dec_hang) begin
        repeat (dec_lat) @(posedge clk);
        #1;
        bus.dec_done_i = 1'b1;
        bus.dec_pass_i = dec_pass_cfg;
        bus.dec_word_i = cword ^ dec_flip;
        @(posedge clk);
        #1 bus.dec_done_i = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_campaign(input logic [15:0] trials, input logic [7:0] errs,
                                input logic [15:0] seed, input logic [15:0] tmo);
    cfg_num_trials = trials; cfg_num_errs = errs; cfg_seed = seed; cfg_timeout = tmo;
    cfg_go = 1'b1;
    tick(1);
    cfg_go = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int k = 0;
    while (irqs_seen < irq_exp && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (irqs_seen < irq_exp) begin
      errors++;
      $display("FAIL irq_wait actual=%0d required=%0d", irqs_seen, irq_exp);
    end
  endtask

  // Returns the number of cycles until dec_start_o is seen (bounded).
  task automatic wait_start(output int k);
    k = 0;
    while (bus.dec_start_o !== 1'b1 && k < 100) begin
      tick(1);
      k++;
    end
  endtask

  initial begin
    logic [NN-1:0] m;
    int s0, k, cyc;
    cfg_go = 1'b0; cfg_abort = 1'b0; cfg_num_trials = '0; cfg_num_errs = '0;
    cfg_seed = '0; cfg_timeout = 16'd100;
    cword = {52{4'hA}} ^ 208'h1234_5678_9ABC_DEF0;
    dec_flip = '0;
    bus.enc_valid_i = 1'b1;
    bus.enc_cword_i = cword;

    // Reset values
    tick(3);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_start", bus.dec_start_o, 0);
    check("rst_mask", bus.err_mask_o, 0);
    check("rst_trial", trial_cnt_o, 0);
    rstn = 1'b1;
    tick(2);

    // Clean codewords, 4 trials, plus a go while busy that must be ignored
    s0 = starts_seen;
    repeat (4) push_start('0);
    push_irq(16'd4, 16'd4, 16'd0, 16'd0);
    start_campaign(16'd4, 8'd0, 16'h1234, 16'd100);
    check("busy_after_go", busy_o, 1);
    tick(10);
    cfg_go = 1'b1; tick(1); cfg_go = 1'b0;
    wait_irq(500);
    check("clean_starts", starts_seen - s0, 4);
    tick(2);
    check("clean_done_sticky", done_o, 1);

    // Hand-computed masks from seed 0x0001, 3 errors, 2 trials
    m = '0; m[1] = 1'b1; m[2] = 1'b1; m[4] = 1'b1;
    push_start(m);
    m = '0; m[8] = 1'b1; m[16] = 1'b1; m[32] = 1'b1;
    push_start(m);
    push_irq(16'd2, 16'd2, 16'd0, 16'd0);
    start_campaign(16'd2, 8'd3, 16'h0001, 16'd100);
    wait_irq(500);
    tick(2);

    // Seed 0x00D0: first position 208 is rejected, then 160, 64, 128
    m = '0; m[160] = 1'b1; m[64] = 1'b1; m[128] = 1'b1;
    push_start(m);
    push_irq(16'd1, 16'd1, 16'd0, 16'd0);
    start_campaign(16'd1, 8'd3, 16'h00D0, 16'd100);
    wait_start(k);
    check("inject_reject_latency", k, 5);
    wait_irq(200);
    tick(2);

    // Seed 0 selects the default seed; positions from the reference model
    m = model_mask(16'hACE1, 4, cyc);
    push_start(m);
    push_irq(16'd1, 16'd1, 16'd0, 16'd0);
    start_campaign(16'd1, 8'd4, 16'h0000, 16'd100);
    wait_start(k);
    check("inject_model_latency", k, cyc + 1);
    wait_irq(300);
    tick(2);

    // Timeout with a hung decoder, 2 trials
    dec_hang = 1'b1;
    push_start('0); push_start('0);
    push_irq(16'd2, 16'd0, 16'd2, 16'd2);
    start_campaign(16'd2, 8'd0, 16'h1234, 16'd50);
    wait_start(k);
    tick(50);
    check("timeout_cnt_edge_before", timeout_cnt_o, 0);
    tick(1);
    check("timeout_cnt_edge_after", timeout_cnt_o, 1);
    check("timeout_fail_after", fail_cnt_o, 1);
    wait_irq(300);
    dec_hang = 1'b0;
    tick(2);

    // Decoded word differs in bit 5
    dec_flip = '0; dec_flip[5] = 1'b1;
    push_start('0);
    push_irq(16'd1, 16'd0, 16'd1, 16'd0);
    start_campaign(16'd1, 8'd0, 16'h1234, 16'd100);
    wait_irq(200);
    dec_flip = '0;
    tick(30);

    // Abort in DEC_WAIT of trial 2 of 10
    s0 = starts_seen;
    push_start('0); push_start('0);
    start_campaign(16'd10, 8'd0, 16'h1234, 16'd100);
    k = 0;
    while (starts_seen < s0 + 2 && k < 200) begin
      tick(1);
      k++;
    end
    check("abort_second_start", starts_seen - s0, 2);
    tick(5);
    cfg_abort = 1'b1; tick(1); cfg_abort = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_trial", trial_cnt_o, 1);
    tick(40);
    check("abort_trial_held", trial_cnt_o, 1);
    check("abort_no_irq", irqs_seen, irq_exp);

    // Asynchronous reset in the middle of a long INJECT
    start_campaign(16'd1, 8'd200, 16'h0001, 16'd100);
    tick(5);
    check("inject_mask_nonzero", (bus.err_mask_o != '0), 1);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_busy", busy_o, 0);
    check("async_rst_mask", bus.err_mask_o, 0);
    check("async_rst_done", done_o, 0);
    tick(2);
    rstn = 1'b1;
    tick(3);
    check("post_rst_idle", busy_o, 0);

    // Zero trials completes without any decoder start
    s0 = starts_seen;
    push_irq(16'd0, 16'd0, 16'd0, 16'd0);
    start_campaign(16'd0, 8'd3, 16'h1234, 16'd100);
    wait_irq(5);
    check("zero_trials_no_start", starts_seen - s0, 0);
    tick(2);
    check("zero_trials_done", done_o, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
